cmp_track_bank: RTL and testbench

- Multi-channel compare-and-track register bank.
- Each channel holds a WIDTH-bit threshold register. Each accepted sample is compared against that channel's threshold, and the threshold is then updated according to a per-sample mode.
- A sweep FSM clears every channel back to a parametrised initial value, one channel per cycle.
- Parametrised successor of the single-channel async-reset compare/update flop used in equivalence-test designs.

---
 rtl/cmp_track_bank.sv | 217 +++++++++++++++++++++
 tb/tb_cmp_track_bank.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_track_bank.sv
`default_nettype none
// ============================================================================
// Module      : cmp_track_bank
// Description : Multi-channel compare-and-track register bank. Each channel
//               holds a WIDTH-bit threshold. An accepted sample is compared
//               against its channel's threshold (pre-update value). The
//               threshold is then updated by the sample's mode: LOAD, MAX,
//               CLR or HOLD. A sweep FSM returns every channel to INIT, one
//               channel per cycle, and pulses clr_done when it finishes.
//
// Ports       : clk, rst     - rising-edge clock, async active-high reset
//               in_valid     - sample present
//               in_ready     - bank accepts a sample (high only when idle)
//               in_ch        - target channel
//               in_data      - sample value
//               in_mode      - 0 LOAD, 1 MAX, 2 CLR, 3 HOLD
//               clr_req      - request a full clear sweep (level, idle only)
//               clr_done     - one-cycle pulse at the end of a sweep
//               out_valid    - compare result valid (1-cycle latency)
//               out_ch       - channel of the result
//               out_gt       - registered in_data > threshold
//               gt_vec       - last compare result per channel
//               rd_ch/rd_thr - combinational threshold read port
//
// Build option: CMP_TRACK_SIGNED_EN - when defined, the compare and the MAX
//               update treat data and thresholds as two's-complement signed.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_track_bank #(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] INIT     = '0,
    localparam int              CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [1:0]          in_mode,
    input  logic                clr_req,
    output logic                clr_done,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_gt,
    output logic [CHANNELS-1:0] gt_vec,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [WIDTH-1:0]    rd_thr
);

    localparam logic [1:0]      c_MODE_LOAD = 2'd0;
    localparam logic [1:0]      c_MODE_MAX  = 2'd1;
    localparam logic [1:0]      c_MODE_CLR  = 2'd2;
    localparam logic [CH_W:0]   c_CHANNELS  = (CH_W+1)'(CHANNELS);
    localparam logic [CH_W-1:0] c_LAST      = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CH_W-1:0] r_idx;
    logic [CH_W-1:0] w_idx_nxt;
    logic            w_ready;
    logic            w_done;
    logic            w_sweep;

    logic            w_accept;
    logic            w_ch_ok;
    logic [CH_W-1:0] w_ch_safe;
    logic [WIDTH-1:0] w_thr_cur;
    logic            w_gt;
    logic [WIDTH-1:0] w_thr [CHANNELS];

    logic            r_out_valid;
    logic            r_out_gt;
    logic [CH_W-1:0] r_out_ch;

    function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_TRACK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Sweep FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM: next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_sweep     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (clr_req) begin
                    w_state_nxt = S_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            S_SWEEP: begin
                w_sweep = 1'b1;
                if (r_idx == c_LAST) begin
                    w_state_nxt = S_DONE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + CH_W'(1);
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign in_ready = w_ready;
    assign clr_done = w_done;

    // ------------------------------------------------------------------
    // Sample path. Out-of-range channels (non-power-of-2 CHANNELS) are
    // accepted but neither compared nor stored; the safe index keeps the
    // threshold read inside the array.
    // ------------------------------------------------------------------
    assign w_accept  = in_valid & w_ready;
    assign w_ch_ok   = ({1'b0, in_ch} < c_CHANNELS);
    assign w_ch_safe = w_ch_ok ? in_ch : '0;
    assign w_thr_cur = w_thr[w_ch_safe];
    assign w_gt      = w_ch_ok & f_gt(in_data, w_thr_cur);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [CH_W-1:0] c_ID = CH_W'(g);

        logic [WIDTH-1:0] r_thr;
        logic             r_gt;
        logic             w_hit;
        logic             w_clr;

        assign w_hit = w_accept & w_ch_ok & (in_ch == c_ID);
        assign w_clr = w_sweep & (r_idx == c_ID);

        // Accept and sweep never coincide (accept needs the idle state),
        // so the priority between them is immaterial.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_thr <= INIT;
                r_gt  <= 1'b0;
            end else if (w_clr) begin
                r_thr <= INIT;
                r_gt  <= 1'b0;
            end else if (w_hit) begin
                r_gt <= w_gt;
                case (in_mode)
                    c_MODE_LOAD: r_thr <= in_data;
                    c_MODE_MAX:  if (w_gt) r_thr <= in_data;
                    c_MODE_CLR:  r_thr <= INIT;
                    default:     r_thr <= r_thr;
                endcase
            end
        end

        assign w_thr[g]  = r_thr;
        assign gt_vec[g] = r_gt;
    end

    // ------------------------------------------------------------------
    // Registered compare result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_gt    <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_gt <= w_gt;
                r_out_ch <= in_ch;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_gt    = r_out_gt;
    assign out_ch    = r_out_ch;

    // Read port shows stored contents, so a same-cycle write is not visible
    // until after the clock edge.
    assign rd_thr = ({1'b0, rd_ch} < c_CHANNELS) ? w_thr[rd_ch] : '0;

endmodule
`default_nettype wire

// File: tb/tb_cmp_track_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cmp_track_bank
// Description : Self-checking bench for cmp_track_bank. A cycle-level model
//               tracks thresholds, compare flags and the busy window of a
//               clear sweep; one process compares the DUT against it on
//               every falling edge, and directed sequences add literal
//               expectations for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_track_bank;

    localparam int               WIDTH    = 8;
    localparam int               CHANNELS = 4;
    localparam int               CH_W     = $clog2(CHANNELS);
    localparam logic [WIDTH-1:0] INIT     = '0;

    localparam int LOAD = 0;
    localparam int MAX  = 1;
    localparam int CLR  = 2;
    localparam int HOLD = 3;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [CH_W-1:0]     in_ch;
    logic [WIDTH-1:0]    in_data;
    logic [1:0]          in_mode;
    logic                clr_req;
    logic                clr_done;
    logic                out_valid;
    logic [CH_W-1:0]     out_ch;
    logic                out_gt;
    logic [CHANNELS-1:0] gt_vec;
    logic [CH_W-1:0]     rd_ch;
    logic [WIDTH-1:0]    rd_thr;

    int checks = 0;
    int errors = 0;

    cmp_track_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .INIT     (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_gt    (out_gt),
        .gt_vec    (gt_vec),
        .rd_ch     (rd_ch),
        .rd_thr    (rd_thr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // busy counts the cycles left before the bank is ready again after a
    // clear request: CHANNELS clearing cycles followed by one done cycle.
    // ------------------------------------------------------------------
    int  m_thr [CHANNELS];
    bit  m_gtv [CHANNELS];
    bit  m_ov  = 1'b0;
    bit  m_og  = 1'b0;
    int  m_och = 0;
    int  busy  = 0;
    bit  m_acc;
    bit  m_g;
    int  m_c;
    logic [CHANNELS-1:0] ev_gt;

    function automatic bit mgt(input int d, input int t);
`ifdef CMP_TRACK_SIGNED_EN
        int sd = (d >= 2**(WIDTH-1)) ? d - 2**WIDTH : d;
        int st = (t >= 2**(WIDTH-1)) ? t - 2**WIDTH : t;
        return sd > st;
`else
        return d > t;
`endif
    endfunction

    initial begin
        for (int i = 0; i < CHANNELS; i++) begin
            m_thr[i] = int'(INIT);
            m_gtv[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_thr[i] = int'(INIT);
                m_gtv[i] = 1'b0;
            end
            m_ov  = 1'b0;
            m_og  = 1'b0;
            m_och = 0;
            busy  = 0;
        end else begin
            m_acc = in_valid && (busy == 0);
            m_ov  = m_acc;
            if (m_acc) begin
                m_c   = int'(in_ch);
                m_och = m_c;
                if (m_c < CHANNELS) begin
                    m_g        = mgt(int'(in_data), m_thr[m_c]);
                    m_og       = m_g;
                    m_gtv[m_c] = m_g;
                    case (int'(in_mode))
                        LOAD:    m_thr[m_c] = int'(in_data);
                        MAX:     if (m_g) m_thr[m_c] = int'(in_data);
                        CLR:     m_thr[m_c] = int'(INIT);
                        default: ;
                    endcase
                end else begin
                    m_og = 1'b0;
                end
            end
            if (busy >= 2) begin
                m_c        = CHANNELS + 1 - busy;
                m_thr[m_c] = int'(INIT);
                m_gtv[m_c] = 1'b0;
                busy       = busy - 1;
            end else if (busy == 1) begin
                busy = 0;
            end else if (clr_req) begin
                busy = CHANNELS + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) ev_gt[i] = m_gtv[i];
            chk("m_in_ready", 32'(in_ready), 32'(busy == 0));
            chk("m_clr_done", 32'(clr_done), 32'(busy == 1));
            chk("m_out_valid", 32'(out_valid), 32'(m_ov));
            chk("m_gt_vec", 32'(gt_vec), 32'(ev_gt));
            chk("m_rd_thr", 32'(rd_thr), 32'(m_thr[int'(rd_ch)]));
            if (m_ov) begin
                chk("m_out_gt", 32'(out_gt), 32'(m_og));
                chk("m_out_ch", 32'(out_ch), 32'(m_och));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1ns after the falling edge
    // ------------------------------------------------------------------
    task automatic drive(input bit v, input int ch, input int d, input int mode, input bit clr);
        @(negedge clk);
        #1;
        in_valid = v;
        in_ch    = CH_W'(ch);
        in_data  = WIDTH'(d);
        in_mode  = 2'(mode);
        clr_req  = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, HOLD, 1'b0);
    endtask

    task automatic chk_thr(input int ch, input int exp);
        rd_ch = CH_W'(ch);
        #1;
        chk($sformatf("rd_thr[%0d]", ch), 32'(rd_thr), 32'(exp));
    endtask

    int n;

    initial begin
        in_valid = 1'b0;
        in_ch    = '0;
        in_data  = '0;
        in_mode  = '0;
        clr_req  = 1'b0;
        rd_ch    = '0;
        rst      = 1'b0;
        #1 rst = 1'b1;
        #5 rst = 1'b0;
        idle();
        idle();

        // Load a channel, then reset between clock edges
        drive(1'b1, 0, 'h22, LOAD, 1'b0);
        idle();
        chk("load_out_gt", 32'(out_gt), 32'd1);
        chk_thr(0, 'h22);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_gt_vec", 32'(gt_vec), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        for (int c = 0; c < CHANNELS; c++) chk_thr(c, int'(INIT));
        rst = 1'b0;

        // LOAD then MAX below the threshold
        drive(1'b1, 1, 'h40, LOAD, 1'b0);
        drive(1'b1, 1, 'h30, MAX, 1'b0);
        chk("ld_out_valid", 32'(out_valid), 32'd1);
        chk("ld_out_gt", 32'(out_gt), 32'd1);
        chk("ld_out_ch", 32'(out_ch), 32'd1);
        chk_thr(1, 'h40);
        idle();
        chk("max_lo_out_gt", 32'(out_gt), 32'd0);
        chk_thr(1, 'h40);
        chk("max_lo_gt_vec", 32'(gt_vec), 32'b0000);

        // MAX above, HOLD above, MAX equal, CLR
        drive(1'b1, 2, 'h80, MAX, 1'b0);
        drive(1'b1, 2, 'h90, HOLD, 1'b0);
        chk("max_hi_out_gt", 32'(out_gt), 32'd1);
        idle();
        chk("hold_out_gt", 32'(out_gt), 32'd1);
        chk_thr(2, 'h80);
        chk("hold_gt_vec", 32'(gt_vec), 32'b0100);
        drive(1'b1, 2, 'h80, MAX, 1'b0);
        idle();
        chk("max_eq_out_gt", 32'(out_gt), 32'd0);
        chk_thr(2, 'h80);
        drive(1'b1, 1, 'hFF, CLR, 1'b0);
        idle();
        chk("clr_out_gt", 32'(out_gt), 32'd1);
        chk_thr(1, int'(INIT));
        chk("clr_gt_vec", 32'(gt_vec), 32'b0010);

        // Load every channel, then a one-cycle clear request
        for (int c = 0; c < CHANNELS; c++) drive(1'b1, c, 'h55, LOAD, 1'b0);
        drive(1'b0, 0, 0, HOLD, 1'b1);
        chk("pre_sweep_gt_vec", 32'(gt_vec), 32'b1011);
        chk_thr(2, 'h55);
        for (int k = 1; k <= CHANNELS + 2; k++) begin
            idle();
            chk($sformatf("sweep_ready_c%0d", k), 32'(in_ready), 32'(k == CHANNELS + 2));
            chk($sformatf("sweep_done_c%0d", k), 32'(clr_done), 32'(k == CHANNELS + 1));
        end
        for (int c = 0; c < CHANNELS; c++) chk_thr(c, int'(INIT));
        chk("post_sweep_gt_vec", 32'(gt_vec), 32'd0);

        // Accept and clear request in the same cycle
        drive(1'b1, 0, 'h11, LOAD, 1'b1);
        idle();
        chk("same_out_valid", 32'(out_valid), 32'd1);
        chk("same_out_gt", 32'(out_gt), 32'd1);
        chk("same_in_ready", 32'(in_ready), 32'd0);
        chk_thr(0, 'h11);
        n = 0;
        while (!in_ready && n < 20) begin
            idle();
            n++;
        end
        chk("same_sweep_len", 32'(n), 32'(CHANNELS + 1));
        chk_thr(0, int'(INIT));

        // Reset in the middle of a sweep (sweep index 2)
        drive(1'b1, 3, 'h77, LOAD, 1'b0);
        drive(1'b0, 0, 0, HOLD, 1'b1);
        idle();
        idle();
        idle();
        chk("mid_sweep_busy", 32'(in_ready), 32'd0);
        chk_thr(3, 'h77);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_clr_done", 32'(clr_done), 32'd0);
        chk_thr(3, int'(INIT));
        rst = 1'b0;
        for (int k = 0; k < CHANNELS + 2; k++) begin
            idle();
            chk("abort_no_done", 32'(clr_done), 32'd0);
        end

        // Signed versus unsigned compare
        drive(1'b1, 3, 'h10, LOAD, 1'b0);
        drive(1'b1, 3, 'hF0, HOLD, 1'b0);
        idle();
`ifdef CMP_TRACK_SIGNED_EN
        chk("sign_out_gt", 32'(out_gt), 32'd0);
`else
        chk("sign_out_gt", 32'(out_gt), 32'd1);
`endif
        chk_thr(3, 'h10);

        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
